// File: rtl/rr_decode_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_decode_arbiter_if
//  Brief    : Request/release and grant bundle between eight requesters and
//             the round-robin decode arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface rr_decode_arbiter_if;
    logic [7:0] req;        // request lines, one per requester
    logic       done;       // release pulse from the current owner
    logic       grant_en;   // decoder enable
    logic [2:0] grant_idx;  // decoder select
    logic [7:0] grant;      // one-hot view of grant_idx
    logic       timeout;    // forced-revoke pulse

    // Requester side: drives requests/release, observes the grant.
    modport master (
        output req,
        output done,
        input  grant_en,
        input  grant_idx,
        input  grant,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant_en,
        output grant_idx,
        output grant,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_decode_arbiter
//  Brief    : Eight-way round-robin arbiter feeding a 3-to-8 decoder stage.
//             Grants are held until released by the owner, withdrawn, or
//             revoked after MAX_HOLD cycles. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16     // 1..255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_decode_arbiter_if.slave    bus
);

    // Last hold-counter value before a grant is forcibly revoked.
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] c_HOLD_SAT  = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold;
    logic       r_grant_en;
    logic [2:0] r_grant_idx;
    logic [7:0] r_grant;
    logic       r_timeout;

    logic       w_pick_valid;
    logic [2:0] w_pick_idx;
    logic       w_owner_req;
    logic       w_expired;
    logic       w_release;
    logic       w_forced;

    // Rotating-priority search: first active request at ptr, ptr+1, ... (mod 8).
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!w_pick_valid && bus.req[r_ptr + 3'(i)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = r_ptr + 3'(i);
            end
        end
    end

    // Release conditions for the current owner; a revoke is "forced" only
    // when the hold limit is the sole reason for giving up the grant.
    always_comb begin
        w_owner_req = bus.req[r_grant_idx];
        w_expired   = (r_hold == c_HOLD_LAST);
        w_release   = bus.done | ~w_owner_req | w_expired;
        w_forced    = w_expired & ~bus.done & w_owner_req;
    end

    // Arbitration FSM with registered decoder select/enable and one-hot grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_hold      <= 8'd0;
            r_grant_en  <= 1'b0;
            r_grant_idx <= 3'd0;
            r_grant     <= 8'h00;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= ST_OWNED;
                        r_grant_en  <= 1'b1;
                        r_grant_idx <= w_pick_idx;
                        r_grant     <= 8'b1 << w_pick_idx;
                        r_hold      <= 8'd0;
                    end
                end
                ST_OWNED: begin
                    if (w_release) begin
                        r_state     <= ST_IDLE;
                        r_grant_en  <= 1'b0;
                        r_grant_idx <= 3'd0;
                        r_grant     <= 8'h00;
                        r_timeout   <= w_forced;
                        r_hold      <= 8'd0;
                        // Owner drops to lowest priority; 3-bit add wraps 7 -> 0.
                        r_ptr       <= r_grant_idx + 3'd1;
                    end else if (r_hold != c_HOLD_SAT) begin
                        r_hold      <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant_en  = r_grant_en;
    assign bus.grant_idx = r_grant_idx;
    assign bus.grant     = r_grant;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_decode_arbiter
//  Brief    : Self-checking bench for rr_decode_arbiter. Two instances
//             (MAX_HOLD=4 and MAX_HOLD=16) share the same stimulus and are
//             compared every cycle against a cycle-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_decode_arbiter;

    localparam int c_MAX_A = 4;
    localparam int c_MAX_B = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_s;
    logic       done_s;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: owner (-1 = none), pointer, cycles held so far,
    // timeout flag, indexed by instance (0 = A, 1 = B).
    int m_owner [2];
    int m_ptr   [2];
    int m_held  [2];
    bit m_tmo   [2];
    int rr_order [6] = '{0, 4, 7, 0, 4, 7};

    rr_decode_arbiter_if ifa ();
    rr_decode_arbiter_if ifb ();

    assign ifa.req  = req_s;
    assign ifa.done = done_s;
    assign ifb.req  = req_s;
    assign ifb.done = done_s;

    rr_decode_arbiter #(.MAX_HOLD(c_MAX_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    rr_decode_arbiter #(.MAX_HOLD(c_MAX_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_owner[j] = -1;
            m_ptr[j]   = 0;
            m_held[j]  = 0;
            m_tmo[j]   = 1'b0;
        end
    endtask

    // One clock edge of the arbiter rules, written in terms of cycles held.
    task automatic model_tick();
        int lim;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int j = 0; j < 2; j++) begin
                lim      = (j == 0) ? c_MAX_A : c_MAX_B;
                m_tmo[j] = 1'b0;
                if (m_owner[j] < 0) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_owner[j] < 0 && req_s[(m_ptr[j] + k) % 8]) begin
                            m_owner[j] = (m_ptr[j] + k) % 8;
                            m_held[j]  = 1;
                        end
                    end
                end else if (done_s || !req_s[m_owner[j]] || m_held[j] == lim) begin
                    m_tmo[j]   = !done_s && req_s[m_owner[j]];
                    m_ptr[j]   = (m_owner[j] + 1) % 8;
                    m_owner[j] = -1;
                    m_held[j]  = 0;
                end else begin
                    m_held[j]++;
                end
            end
        end
    endtask

    function automatic logic [12:0] exp_vec(input int j);
        if (m_owner[j] >= 0)
            return {1'b1, 3'(m_owner[j]), 8'(1 << m_owner[j]), m_tmo[j]};
        return {1'b0, 3'd0, 8'h00, m_tmo[j]};
    endfunction

    task automatic compare_all();
        chk("model_a", 32'({ifa.grant_en, ifa.grant_idx, ifa.grant, ifa.timeout}), 32'(exp_vec(0)));
        chk("model_b", 32'({ifb.grant_en, ifb.grant_idx, ifb.grant, ifb.timeout}), 32'(exp_vec(1)));
    endtask

    // Advance one clock: model follows the edge, outputs compared 1 time unit
    // later, and control returns at the falling edge for the next drive.
    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        req_s  = 8'h00;
        done_s = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        chk("rst_en_a",   32'(ifa.grant_en),  32'd0);
        chk("rst_grant_a", 32'(ifa.grant),    32'h00);
        chk("rst_idx_b",  32'(ifb.grant_idx), 32'd0);
        chk("rst_tmo_b",  32'(ifb.timeout),   32'd0);
        rst_n = 1'b1;

        // Single requester 5, released by done in its third owned cycle.
        req_s = 8'h20;
        step();
        chk("single_idx_a",   32'(ifa.grant_idx), 32'd5);
        chk("single_grant_a", 32'(ifa.grant),     32'h20);
        chk("single_grant_b", 32'(ifb.grant),     32'h20);
        step();
        step();
        chk("single_c3_en", 32'(ifa.grant_en), 32'd1);
        done_s = 1'b1;
        step();
        done_s = 1'b0;
        chk("single_gap_en", 32'(ifa.grant_en), 32'd0);
        step();
        chk("single_regrant_idx", 32'(ifa.grant_idx), 32'd5);
        chk("single_regrant_en",  32'(ifa.grant_en),  32'd1);

        // Owner withdraws: released next edge without timeout.
        req_s = 8'h00;
        step();
        chk("withdraw5_en",  32'(ifa.grant_en), 32'd0);
        chk("withdraw5_tmo", 32'(ifa.timeout),  32'd0);

        // Asynchronous reset in the middle of a grant.
        req_s = 8'hFF;
        step();
        chk("prerst_idx", 32'(ifa.grant_idx), 32'd6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_en_a",    32'(ifa.grant_en),  32'd0);
        chk("async_grant_a", 32'(ifa.grant),     32'h00);
        chk("async_idx_b",   32'(ifb.grant_idx), 32'd0);
        chk("async_grant_b", 32'(ifb.grant),     32'h00);
        step();
        rst_n = 1'b1;
        req_s = 8'h00;
        repeat (4) step();
        chk("quiet_en",    32'(ifa.grant_en), 32'd0);
        chk("quiet_grant", 32'(ifb.grant),    32'h00);

        // Round-robin among 0, 4, 7 starting from ptr 0.
        req_s = 8'h91;
        foreach (rr_order[i]) begin
            step();
            chk("rr_idx", 32'(ifa.grant_idx), 32'(rr_order[i]));
            chk("rr_en",  32'(ifa.grant_en),  32'd1);
            done_s = 1'b1;
            step();
            done_s = 1'b0;
            chk("rr_gap", 32'(ifa.grant_en), 32'd0);
        end

        // Timeout on instance A (MAX_HOLD=4).
        req_s = 8'h03;
        step();
        chk("to_c1_idx", 32'(ifa.grant_idx), 32'd0);
        repeat (3) begin
            step();
            chk("to_hold_en", 32'(ifa.grant_en), 32'd1);
        end
        step();
        chk("to_pulse", {30'd0, ifa.grant_en, ifa.timeout}, 32'b01);
        step();
        chk("to_next1", {28'd0, ifa.grant_idx, ifa.timeout}, {28'd0, 3'd1, 1'b0});
        repeat (4) step();
        chk("to_pulse2", 32'(ifa.timeout), 32'd1);
        step();
        chk("to_back0", {28'd0, ifa.grant_en, ifa.grant_idx}, {28'd0, 1'b1, 3'd0});
        req_s = 8'h00;
        step();
        chk("to_withdraw_tmo", 32'(ifa.timeout), 32'd0);

        // Owner 2 withdraws.
        req_s = 8'h04;
        step();
        chk("w2_idx_a", 32'(ifa.grant_idx), 32'd2);
        chk("w2_idx_b", 32'(ifb.grant_idx), 32'd2);
        req_s = 8'h00;
        step();
        chk("w2_rel", {30'd0, ifa.grant_en, ifa.timeout}, 32'b00);

        // done coincident with the last allowed cycle: normal release.
        req_s = 8'h04;
        step();
        chk("simul_c1", 32'(ifa.grant_idx), 32'd2);
        repeat (3) step();
        chk("simul_c4", 32'(ifa.grant_en), 32'd1);
        done_s = 1'b1;
        step();
        done_s = 1'b0;
        req_s  = 8'h00;
        chk("simul_rel", {30'd0, ifa.grant_en, ifa.timeout}, 32'b00);

        // Wrap-around: after owner 6, ptr=7 so 0 wins over 6.
        req_s = 8'h40;
        step();
        chk("wrap_6a", 32'(ifa.grant_idx), 32'd6);
        done_s = 1'b1;
        step();
        done_s = 1'b0;
        req_s  = 8'h41;
        step();
        chk("wrap_0", 32'(ifa.grant_idx), 32'd0);
        done_s = 1'b1;
        step();
        done_s = 1'b0;
        step();
        chk("wrap_6b", 32'(ifa.grant_idx), 32'd6);
        req_s = 8'h00;
        step();
        step();

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0)
                req_s = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom & $urandom);
            done_s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
            end
            step();
        end
        done_s = 1'b0;
        req_s  = 8'h00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter that shares one decoded resource slot among eight requesters. It selects one active requester and drives a registered 3-bit index plus enable, which are the select/enable inputs of the 3-to-8 decoder stage. It also presents the equivalent one-hot grant vector. A grant is held until the owner releases it or a hold timeout expires. A rotating priority pointer guarantees fairness.

## Interface

- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk` (input, 1): rising-edge clock; the only clock.
- `rst_n` (input, 1): asynchronous, active-low reset.
- `req` (input, 8): request lines; `req[i]` high = requester i wants the resource.
- `done` (input, 1): single-cycle release pulse from the current owner; ignored when no grant is active.
- `grant_en` (output, 1): high while a grant is active; drives the decoder enable.
- `grant_idx` (output, 3): index of the current owner; drives the decoder select; 0 when `grant_en`=0.
- `grant` (output, 8): one-hot equal to `1<<grant_idx` when `grant_en`=1, else 8'h00.
- `timeout` (output, 1): one-cycle pulse on the cycle after a grant was forcibly revoked.

## Operation

- **Reset:** clock/reset are one clock plus an asynchronous, active-low reset (`clk`, `rst_n`). Reset values:
  - state=IDLE, `grant_en`=0, `grant_idx`=0, `grant`=8'h00, `timeout`=0
  - priority pointer `ptr`=0, hold counter=0
- **States:** IDLE and OWNED.
- **IDLE:**
  - If `req`==0, stay in IDLE.
  - Otherwise pick the first set bit scanning `ptr`, `ptr+1`, …, `ptr+7` (mod 8). Register it into `grant_idx`, set `grant_en`=1, clear the hold counter, go to OWNED.
- **OWNED:** the hold counter increments each cycle. The grant is released at the clock edge following any of these:
  - (a) `done`=1;
  - (b) `req[grant_idx]`=0 (requester withdrew);
  - (c) hold counter == `MAX_HOLD`-1 with neither (a) nor (b) true. This is a forced revoke: `timeout` pulses for one cycle.
- **On release:**
  - state → IDLE, `grant_en`=0, `grant_idx`=0;
  - `ptr` ← `grant_idx`+1 (mod 8; 7 wraps to 0).
- **Simultaneous events:**
  - `done` and timeout in the same cycle count as a normal release, so `timeout` stays 0.
  - `req` changes on other lines during OWNED have no effect until the next IDLE.
- **Width rules:**
  - The hold counter is 8 bits and saturates; it never wraps within a grant.
  - `ptr` arithmetic is modulo 8.
- **Reset mid-grant:** all outputs go to reset values immediately (asynchronous); `ptr` returns to 0.

## Timing

- Arbitration latency: `req` sampled in IDLE at edge N gives `grant_en`/`grant_idx`/`grant` valid after edge N.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.
- Release latency: a release condition sampled at edge N gives `grant_en`=0 after edge N.
- There is exactly one IDLE cycle between consecutive grants, so the minimum grant period is 2 cycles.
- Maximum grant duration is `MAX_HOLD` cycles with `grant_en` high.
- `timeout` is high for the single cycle after the revoking edge, coincident with that IDLE cycle.
- Worst-case wait for a continuously requesting line is 7×(`MAX_HOLD`+1) cycles.

## Test plan

- **Reset/idle:** assert `rst_n`=0 mid-grant with `req`=8'hFF.
  - All outputs are 0 asynchronously.
  - After release with `req`=8'h00, outputs stay 0 indefinitely.
- **Single requester:** `req`=8'h20 held, `done` pulsed 3 cycles after the grant.
  - `grant_idx`=5 and `grant`=8'h20 for exactly 3 cycles.
  - Then one idle cycle, then a re-grant to 5 (`ptr`=6, no other requester).
- **Round-robin fairness:** `req`=8'h91 held, `done` pulsed each grant's first cycle.
  - Grant order is 0, 4, 7, 0, 4, …
  - Each grant is separated by one idle cycle.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h03, `done` never asserted.
  - Grant 0 lasts 4 cycles, then `timeout`=1 for one cycle.
  - Next grant is 1; the next timeout returns the grant to 0.
- **Withdrawal and simultaneous release:**
  - Owner 2 drops `req[2]` → grant released next edge, `timeout`=0.
  - With `MAX_HOLD`=4 and `done` asserted on the 4th owned cycle → release with `timeout`=0.
- **Wrap-around:** `ptr`=7 (after owner 6), `req`=8'h41.
  - Next grant is 0, not 6; after that, `ptr`=1, so the grant after that is 6.
